// File: rtl/axi_pkg.sv
// Shared AXI response codes, burst encodings and FSM state types
// for the AXI slave memory.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-word-index calculator for one AXI burst channel.
// WRAP bursts are supported only when AXI_SLAVE_MEM_WRAP_EN is defined.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int IDX_W = 30
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       len,
    input  burst_t           burst,
    output logic [IDX_W-1:0] next_idx,
    output logic             burst_err
);

    logic [IDX_W-1:0] inc_idx;

    assign inc_idx = idx + 1'b1;

`ifdef AXI_SLAVE_MEM_WRAP_EN
    logic [IDX_W-1:0] wrap_mask;
    logic             wrap_ok;

    // The wrap window is len+1 words, so len itself is the in-window offset mask
    assign wrap_mask = IDX_W'(len);
    assign wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
    logic unused_len;

    assign unused_len = ^len;
`endif

    always_comb begin
        next_idx  = idx;
        burst_err = 1'b0;
        case (burst)
            BURST_FIXED: next_idx = idx;
            BURST_INCR:  next_idx = inc_idx;
`ifdef AXI_SLAVE_MEM_WRAP_EN
            BURST_WRAP: begin
                next_idx  = (idx & ~wrap_mask) | (inc_idx & wrap_mask);
                burst_err = !wrap_ok;
            end
`else
            BURST_WRAP:  burst_err = 1'b1;
`endif
            default:     burst_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word-addressed memory with independent read and write FSMs.
// Optional WRAP burst support via AXI_SLAVE_MEM_WRAP_EN.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return i < IDX_W'(DEPTH);
    endfunction

    // Burst length is carried by awlen; sub-word address bits do not select anything
    logic unused_inputs;
    assign unused_inputs = ^{wlast, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

    wr_state_t           wr_state, wr_state_nxt;
    logic [ID_WIDTH-1:0] wr_id;
    logic [IDX_W-1:0]    wr_idx, wr_idx_nxt;
    logic [7:0]          wr_len, wr_cnt;
    burst_t              wr_burst;
    logic                wr_err_acc, wr_burst_err;
    logic                wr_beat, wr_last, wr_beat_err;

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_gen (
        .idx       (wr_idx),
        .len       (wr_len),
        .burst     (wr_burst),
        .next_idx  (wr_idx_nxt),
        .burst_err (wr_burst_err)
    );

    assign wr_beat     = wready && wvalid;
    assign wr_last     = (wr_cnt == wr_len);
    assign wr_beat_err = wr_burst_err || !in_range(wr_idx);
    assign bid         = wr_id;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) wr_state <= W_IDLE;
        else        wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wr_last) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_id      <= '0;
            wr_idx     <= '0;
            wr_len     <= '0;
            wr_cnt     <= '0;
            wr_burst   <= BURST_FIXED;
            wr_err_acc <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            if (awready && awvalid) begin
                wr_id      <= awid;
                wr_idx     <= awaddr[ADDR_WIDTH-1:OFF_W];
                wr_len     <= awlen;
                wr_burst   <= burst_t'(awburst);
                wr_cnt     <= '0;
                wr_err_acc <= 1'b0;
            end
            if (wr_beat) begin
                wr_idx     <= wr_idx_nxt;
                wr_cnt     <= wr_cnt + 8'd1;
                wr_err_acc <= wr_err_acc | wr_beat_err;
                if (wr_last) bresp <= (wr_err_acc | wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge aclk) begin
        if (wr_beat && !wr_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[wr_idx[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    rd_state_t             rd_state, rd_state_nxt;
    logic [IDX_W-1:0]      rd_idx, rd_gen_idx, rd_idx_nxt;
    logic [7:0]            rd_len, rd_beat, rd_gen_len;
    burst_t                rd_burst, rd_gen_burst;
    logic                  rd_burst_err, rd_fetch_err;
    logic [DATA_WIDTH-1:0] rd_fetch_data;

    // In R_IDLE the generator sees the incoming AR request so the first beat can be fetched at once
    assign rd_gen_idx   = (rd_state == R_IDLE) ? araddr[ADDR_WIDTH-1:OFF_W] : rd_idx;
    assign rd_gen_len   = (rd_state == R_IDLE) ? arlen : rd_len;
    assign rd_gen_burst = (rd_state == R_IDLE) ? burst_t'(arburst) : rd_burst;

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_gen (
        .idx       (rd_gen_idx),
        .len       (rd_gen_len),
        .burst     (rd_gen_burst),
        .next_idx  (rd_idx_nxt),
        .burst_err (rd_burst_err)
    );

    assign rd_fetch_err  = rd_burst_err || !in_range(rd_gen_idx);
    assign rd_fetch_data = rd_fetch_err ? '0 : mem[rd_gen_idx[MEM_AW-1:0]];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rd_state <= R_IDLE;
        else        rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rd_state_nxt = R_BURST;
            end
            R_BURST: begin
                rvalid = 1'b1;
                if (rready && rlast) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rlast    <= 1'b0;
            rd_idx   <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_burst <= BURST_FIXED;
        end else if (arready && arvalid) begin
            rid      <= arid;
            rd_len   <= arlen;
            rd_burst <= burst_t'(arburst);
            rd_beat  <= '0;
            rlast    <= (arlen == 8'd0);
            rd_idx   <= rd_idx_nxt;
            rdata    <= rd_fetch_data;
            rresp    <= rd_fetch_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid && rready) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                rd_beat <= rd_beat + 8'd1;
                rlast   <= ((rd_beat + 8'd1) == rd_len);
                rd_idx  <= rd_idx_nxt;
                rdata   <= rd_fetch_data;
                rresp   <= rd_fetch_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem
Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits; SHALL be one of 32 or 64.
REQ-002 ADDR_WIDTH, 32, byte address width.
REQ-003 DEPTH, 1024, memory size in DATA_WIDTH-bit words.
REQ-004 ID_WIDTH, 4, transaction ID width.
REQ-005 aclk  input  1  clock; all logic on the rising edge.
REQ-006 areset  input  1  asynchronous, active-high reset.
REQ-007 awid  input  ID_WIDTH  write address ID.
REQ-008 awaddr  input  ADDR_WIDTH  write start byte address.
REQ-009 awlen  input  8  write beats minus one.
REQ-010 awburst  input  2  write burst type (FIXED/INCR/WRAP).
REQ-011 awvalid  input  1  write address valid.
REQ-012 awready  output  1  write address ready.
REQ-013 wdata  input  DATA_WIDTH  write data.
REQ-014 wstrb  input  DATA_WIDTH/8  byte write strobes.
REQ-015 wlast  input  1  last write beat (ignored).
REQ-016 wvalid  input  1  write data valid.
REQ-017 wready  output  1  write data ready.
REQ-018 bid  output  ID_WIDTH  response ID.
REQ-019 bresp  output  2  write response.
REQ-020 bvalid  output  1  write response valid.
REQ-021 bready  input  1  write response ready.
REQ-022 arid  input  ID_WIDTH  read address ID.
REQ-023 araddr  input  ADDR_WIDTH  read start byte address.
REQ-024 arlen  input  8  read beats minus one.
REQ-025 arburst  input  2  read burst type.
REQ-026 arvalid  input  1  read address valid.
REQ-027 arready  output  1  read address ready.
REQ-028 rid  output  ID_WIDTH  read ID.
REQ-029 rdata  output  DATA_WIDTH  read data.
REQ-030 rresp  output  2  read response.
REQ-031 rlast  output  1  last read beat.
REQ-032 rvalid  output  1  read data valid.
REQ-033 rready  input  1  read data ready.
Function
REQ-034 The write FSM SHALL follow W_IDLE->W_DATA->W_RESP->W_IDLE. awready=1 only in W_IDLE. An AW handshake at cycle N latches ID/address/len/burst and raises wready at N+1. Every wvalid&&wready beat writes the strobed bytes. The burst ends on beat awlen+1, with bvalid=1 and bid=awid on the next cycle, held until bready.
REQ-035 The read FSM SHALL follow R_IDLE->R_BURST->R_IDLE. arready=1 only in R_IDLE. An AR handshake at cycle N gives the first registered beat (rvalid, rid=arid) at N+1, then one beat per cycle while rready=1. rdata/rresp/rlast SHALL hold stable while rvalid&&!rready. rlast=1 only on beat arlen+1; R_IDLE is re-entered when that beat is accepted.
REQ-036 The word index SHALL be addr>>log2(DATA_WIDTH/8), with low bits ignored. Per-beat advance: FIXED holds; INCR +1, wrapping modulo 2^ADDR_WIDTH; WRAP wraps within a (len+1)-word aligned window, len+1 in {2,4,8,16}; burst type 2'b11 SHALL give SLVERR.
REQ-037 Any beat with word index >= DEPTH SHALL not write and SHALL return rdata=0; rresp=SLVERR per beat; bresp SHALL be SLVERR if any beat of the burst was out of range, else OKAY.
REQ-038 Read and write channels SHALL operate concurrently; a same-cycle read and write to one word SHALL return the old data.
Reset
REQ-039 During areset: awready=arready=1; wready=bvalid=rvalid=rlast=0; bid=rid=0; bresp=rresp=OKAY; rdata=0; both FSMs IDLE. Reset mid-burst SHALL abort with no response, leaving already-written beats in memory; memory contents are not cleared.
Configuration
REQ-040 AXI_SLAVE_MEM_WRAP_EN defined: WRAP bursts behave per REQ-036. Undefined: every WRAP burst SHALL perform no writes, return rdata=0, and respond SLVERR on all beats and on bresp.
Structure
REQ-041 Package axi_pkg SHALL hold response codes (OKAY=0, SLVERR=2), burst-type codes and FSM state enums; sub-module axi_burst_addr_gen SHALL compute next-word-index and be instanced once per channel.
Verification
REQ-042 INCR write awaddr=0x10 awlen=3 data 0xA0..0xA3 strobe 0xF, then read same -> bvalid one cycle after 4th beat, bresp=OKAY, reads 0xA0..0xA3, rlast on beat 4.
REQ-043 Write 0x11223344 to 0x0, then wstrb=0x2 wdata=0xFFFFFFFF -> read returns 0x1122FF44.
REQ-044 WRAP read araddr=0x18 arlen=3 (macro defined) -> word order 6,7,4,5; macro undefined -> 4 beats rresp=SLVERR, rdata=0.
REQ-045 Read at byte address DEPTH*4 with arlen=1 -> 2 beats rresp=SLVERR, rdata=0; rready held low 3 cycles -> rdata/rlast stable.
REQ-046 areset asserted after 2 of 4 write beats -> wready=0 and bvalid=0 immediately, awready=1; first 2 words written, words 3-4 unchanged.
